pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Fetch stage of the processor: owns the program counter, addresses the program ROM and latches the fetched word.
//  It presents that word as the instruction register (IR) that the control block decodes.
//  It consumes PcSel and the ALU jump target from the execute stage to step, stall or redirect the PC.
//  It also synchronises the raw Sw8 switch used by WAIT0/WAIT1.
// PARAMETERS
//  PC_WIDTH     8   program counter / ROM address width
//  INSTR_WIDTH  16  instruction word width; opcode sits in the top opcodes::OPCODE_WIDTH bits
// PORTS
//  Clock      in   1            system clock, all flops rising edge
//  nReset     in   1            asynchronous, active-low reset
//  PcSel      in   PcSel_t      next-PC select from control (PcInc/PcWait/PcJmp)
//  JmpTarget  in   PC_WIDTH     jump destination, low PC_WIDTH bits of ALU result
//  ProgData   in   INSTR_WIDTH  ROM read data, combinational from ProgAddr
//  SwRaw      in   1            raw asynchronous switch 8
//  ProgAddr   out  PC_WIDTH     ROM address = fetch PC
//  Instr      out  INSTR_WIDTH  instruction register (execute-stage instruction)
//  ExPc       out  PC_WIDTH     address of the instruction currently in Instr (ALU Op2 for JMP/JMPI)
//  InstrValid out  1            1 = Instr is a real fetched word; 0 = reset/flush bubble
//  Sw8        out  1            synchronised switch to control
// BEHAVIOUR
//  - Two-stage pipeline: fetch (PC -> ROM) and execute (Instr decoded by control in the same cycle).
//  - Reset (async, nReset=0): PC=0, Instr=NOOP_WORD (all zero), ExPc=0, InstrValid=0, both sync flops=0, Sw8=0.
//    A reset asserted mid-operation clears everything immediately, and no partial jump or stall survives.
//  - First edge after reset release: Instr<=ROM[0], ExPc<=0, InstrValid<=1, PC<=1.
//  - Each rising edge, by PcSel (PcSel is a function of the current Instr):
//      PcInc : Instr<=ProgData, ExPc<=PC, PC<=PC+1, InstrValid<=1
//      PcWait: PC, Instr, ExPc, InstrValid all held (stall; the WAIT instruction re-executes every cycle)
//      PcJmp : PC<=JmpTarget, Instr<=NOOP_WORD, InstrValid<=0, ExPc<=ExPc (flush the wrong-path fetch)
//    Next edge after PcJmp: Instr<=ROM[JmpTarget], ExPc<=JmpTarget, PC<=JmpTarget+1.
//  - Taken jump costs exactly one bubble cycle. Non-jump throughput is 1 instr/cycle.
//  - An unused or unknown PcSel encoding behaves as PcInc. The bench flags it via an assertion.
//  - PC arithmetic is modulo 2**PC_WIDTH: PC=2**PC_WIDTH-1 with PcInc wraps to 0, and no flag is raised.
//  - JmpTarget is used as-is (truncated ALU result). Jumping to the last address is legal and wraps normally after.
//  - A bubble decodes as NOOP, so control yields PcInc. A jump therefore can never be followed by a stall on the bubble.
//  - Back-to-back jumps (target holds a jump) are legal: bubble, jump executes, bubble.
//  - Sw8 = SwRaw through a 2-flop synchroniser, with 2-cycle latency.
//    WAIT release is seen on the edge after Sw8 changes, and the PC advances on that edge.
//  - ProgAddr = PC combinationally from the register, with no extra logic in the ROM path.
// STRUCTURE
//  - opcodes package: add NOOP_WORD, OPCODE_WIDTH and default PC_WIDTH/INSTR_WIDTH constants.
//    Reuse the existing PcSel_t. No new PcSel values.
//  - Sub-module sync2 (generic 2-flop synchroniser, async active-low reset to 0) for SwRaw.
//  - Top level: PC register, IR/ExPc/InstrValid registers, next-PC mux. No FSM beyond the stall/flush control.
// TESTING
//  - Reset: nReset=0 mid-stream with PC=0x37 -> PC=0, Instr=0, InstrValid=0 immediately.
//    Release -> ProgAddr 0,1,2 on successive edges.
//  - Sequential fetch: ROM[n]=n+0x100, PcSel=PcInc x5 -> Instr 0x100..0x104 with ExPc 0..4, InstrValid=1 throughout.
//  - Stall: PcSel=PcWait for 3 cycles at PC=5 -> PC, Instr and ExPc frozen.
//    PcInc -> fetch resumes at 5 with no instruction lost or duplicated.
//  - Jump: PcJmp with JmpTarget=0x40 -> next cycle Instr=NOOP, InstrValid=0.
//    Following cycle Instr=ROM[0x40], ExPc=0x40, PC=0x41.
//  - Wrap: PC=0xFF with PcInc -> PC=0x00. Jump to 0xFF -> ExPc=0xFF, then PC=0x00.
//  - Sw8: SwRaw toggles 0->1 -> Sw8 rises exactly 2 edges later.
//    With WAIT0 held, PcSel goes PcWait->PcInc on the cycle Sw8=1.

Source files
------------

// File: rtl/opcodes.sv
// Shared opcode constants and the next-PC select encoding used by control and fetch.
package opcodes;

    localparam int PC_WIDTH_DEF    = 8;
    localparam int INSTR_WIDTH_DEF = 16;
    localparam int OPCODE_WIDTH    = 4;

    localparam logic [INSTR_WIDTH_DEF-1:0] NOOP_WORD = '0;

    typedef enum logic [1:0] {
        PcInc  = 2'b00,
        PcWait = 2'b01,
        PcJmp  = 2'b10
    } PcSel_t;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOOP  = 4'h0,
        OP_JMP   = 4'h1,
        OP_JMPI  = 4'h2,
        OP_WAIT0 = 4'h3,
        OP_WAIT1 = 4'h4
    } opcode_t;

    function automatic logic [OPCODE_WIDTH-1:0] get_opcode(input logic [INSTR_WIDTH_DEF-1:0] instr);
        return instr[INSTR_WIDTH_DEF-1 -: OPCODE_WIDTH];
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs; clears to 0 on reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: program counter, ROM addressing, instruction register with stall/flush, and Sw8 sync.
module pc_fetch
    import opcodes::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  PcSel_t                 PcSel,
    input  logic [PC_WIDTH-1:0]    JmpTarget,
    input  logic [INSTR_WIDTH-1:0] ProgData,
    input  logic                   SwRaw,
    output logic [PC_WIDTH-1:0]    ProgAddr,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    ExPc,
    output logic                   InstrValid,
    output logic                   Sw8
);

    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_ex_pc;
    logic                   r_valid;

    logic [PC_WIDTH-1:0]    w_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_instr_nxt;
    logic [PC_WIDTH-1:0]    w_ex_pc_nxt;
    logic                   w_valid_nxt;

    // Unknown select codes fall through to the sequential-fetch default.
    always_comb begin
        w_pc_nxt    = r_pc + PC_WIDTH'(1);
        w_instr_nxt = ProgData;
        w_ex_pc_nxt = r_pc;
        w_valid_nxt = 1'b1;
        case (PcSel)
            PcWait: begin
                w_pc_nxt    = r_pc;
                w_instr_nxt = r_instr;
                w_ex_pc_nxt = r_ex_pc;
                w_valid_nxt = r_valid;
            end
            PcJmp: begin
                w_pc_nxt    = JmpTarget;
                w_instr_nxt = INSTR_WIDTH'(NOOP_WORD);
                w_ex_pc_nxt = r_ex_pc;
                w_valid_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_pc    <= '0;
            r_instr <= INSTR_WIDTH'(NOOP_WORD);
            r_ex_pc <= '0;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ex_pc <= w_ex_pc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    sync2 #(.WIDTH(1)) u_sw8_sync (
        .Clock   (Clock),
        .nReset  (nReset),
        .i_async (SwRaw),
        .o_sync  (Sw8)
    );

    assign ProgAddr   = r_pc;
    assign Instr      = r_instr;
    assign ExPc       = r_ex_pc;
    assign InstrValid = r_valid;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, corner sequences, randomized model check.
module tb_pc_fetch;
    import opcodes::*;

    logic        Clock = 1'b0;
    logic        nReset;
    PcSel_t      PcSel;
    logic [7:0]  JmpTarget;
    logic [15:0] ProgData;
    logic        SwRaw;
    logic [7:0]  ProgAddr;
    logic [15:0] Instr;
    logic [7:0]  ExPc;
    logic        InstrValid;
    logic        Sw8;

    logic [15:0] rom [256];

    int tests  = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    assign ProgData = rom[ProgAddr];

    pc_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .PcSel      (PcSel),
        .JmpTarget  (JmpTarget),
        .ProgData   (ProgData),
        .SwRaw      (SwRaw),
        .ProgAddr   (ProgAddr),
        .Instr      (Instr),
        .ExPc       (ExPc),
        .InstrValid (InstrValid),
        .Sw8        (Sw8)
    );

    always @(posedge Clock) begin
        if (nReset) begin
            assert (PcSel == PcInc || PcSel == PcWait || PcSel == PcJmp)
                else $error("FAIL pcsel_legal: got %0b required one of 00/01/10", PcSel);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input PcSel_t s, input logic [7:0] t);
        PcSel     = s;
        JmpTarget = t;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    typedef struct {
        PcSel_t sel;
        int     tgt;
        int     pc;
        int     instr;
        int     expc;
        int     vld;
    } vec_t;

    vec_t vecs [21];

    int          pc0;
    int          edges;
    int          m_pc;
    int          m_ir;
    int          m_vld;
    bit          swq [$];
    PcSel_t      rsel;
    int          r;
    logic [7:0]  rtgt;

    initial begin
        vecs[0]  = '{PcInc,  0,    8'h01, 16'h100, 8'h00, 1};
        vecs[1]  = '{PcInc,  0,    8'h02, 16'h101, 8'h01, 1};
        vecs[2]  = '{PcInc,  0,    8'h03, 16'h102, 8'h02, 1};
        vecs[3]  = '{PcInc,  0,    8'h04, 16'h103, 8'h03, 1};
        vecs[4]  = '{PcInc,  0,    8'h05, 16'h104, 8'h04, 1};
        vecs[5]  = '{PcWait, 0,    8'h05, 16'h104, 8'h04, 1};
        vecs[6]  = '{PcWait, 8'h33,8'h05, 16'h104, 8'h04, 1};
        vecs[7]  = '{PcWait, 0,    8'h05, 16'h104, 8'h04, 1};
        vecs[8]  = '{PcInc,  0,    8'h06, 16'h105, 8'h05, 1};
        vecs[9]  = '{PcJmp,  8'h40,8'h40, 16'h000, 8'h05, 0};
        vecs[10] = '{PcInc,  0,    8'h41, 16'h140, 8'h40, 1};
        vecs[11] = '{PcJmp,  8'hFF,8'hFF, 16'h000, 8'h40, 0};
        vecs[12] = '{PcInc,  0,    8'h00, 16'h1FF, 8'hFF, 1};
        vecs[13] = '{PcInc,  0,    8'h01, 16'h100, 8'h00, 1};
        vecs[14] = '{PcJmp,  8'hFE,8'hFE, 16'h000, 8'h00, 0};
        vecs[15] = '{PcInc,  0,    8'hFF, 16'h1FE, 8'hFE, 1};
        vecs[16] = '{PcInc,  0,    8'h00, 16'h1FF, 8'hFF, 1};
        vecs[17] = '{PcJmp,  8'h10,8'h10, 16'h000, 8'hFF, 0};
        vecs[18] = '{PcInc,  0,    8'h11, 16'h110, 8'h10, 1};
        vecs[19] = '{PcJmp,  8'h20,8'h20, 16'h000, 8'h10, 0};
        vecs[20] = '{PcInc,  0,    8'h21, 16'h120, 8'h20, 1};

        for (int i = 0; i < 256; i++) rom[i] = 16'(i + 16'h100);

        nReset    = 1'b0;
        SwRaw     = 1'b0;
        PcSel     = PcInc;
        JmpTarget = 8'h00;
        @(negedge Clock);
        @(negedge Clock);
        chk("reset_pc",    int'(ProgAddr),   0);
        chk("reset_instr", int'(Instr),      0);
        chk("reset_expc",  int'(ExPc),       0);
        chk("reset_valid", int'(InstrValid), 0);
        chk("reset_sw8",   int'(Sw8),        0);
        nReset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].sel, 8'(vecs[i].tgt));
            chk($sformatf("vec%0d_pc", i),    int'(ProgAddr),   vecs[i].pc);
            chk($sformatf("vec%0d_instr", i), int'(Instr),      vecs[i].instr);
            chk($sformatf("vec%0d_expc", i),  int'(ExPc),       vecs[i].expc);
            chk($sformatf("vec%0d_valid", i), int'(InstrValid), vecs[i].vld);
        end

        // Asynchronous reset mid-stream at PC=0x37.
        step(PcJmp, 8'h37);
        chk("pre_reset_pc", int'(ProgAddr), 8'h37);
        nReset = 1'b0;
        #1;
        chk("midrst_pc",    int'(ProgAddr),   0);
        chk("midrst_instr", int'(Instr),      0);
        chk("midrst_valid", int'(InstrValid), 0);
        chk("midrst_expc",  int'(ExPc),       0);
        @(negedge Clock);
        chk("midrst_hold_pc", int'(ProgAddr), 0);
        nReset = 1'b1;
        chk("release_addr0", int'(ProgAddr), 0);
        step(PcInc, 8'h00);
        chk("release_addr1",  int'(ProgAddr), 1);
        chk("release_instr1", int'(Instr),    16'h100);
        step(PcInc, 8'h00);
        chk("release_addr2",  int'(ProgAddr), 2);

        // Switch synchroniser latency.
        SwRaw = 1'b1;
        step(PcInc, 8'h00);
        chk("sw8_after1", int'(Sw8), 0);
        step(PcInc, 8'h00);
        chk("sw8_after2", int'(Sw8), 1);
        SwRaw = 1'b0;
        step(PcInc, 8'h00);
        step(PcInc, 8'h00);
        chk("sw8_fall", int'(Sw8), 0);

        // WAIT held until Sw8 rises; PC advances on the edge after Sw8=1.
        pc0 = int'(ProgAddr);
        for (int i = 0; i < 3; i++) begin
            step(Sw8 ? PcInc : PcWait, 8'h00);
            chk("wait_frozen", int'(ProgAddr), pc0);
        end
        SwRaw = 1'b1;
        edges = 0;
        for (int i = 0; i < 8; i++) begin
            step(Sw8 ? PcInc : PcWait, 8'h00);
            edges++;
            if (int'(ProgAddr) != pc0) break;
        end
        chk("wait_release_edges", edges, 3);
        chk("wait_release_pc", int'(ProgAddr), (pc0 + 1) % 256);

        // Randomized run against a behavioural model.
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        nReset = 1'b0;
        #1;
        nReset = 1'b1;
        m_pc = 0; m_ir = 0; m_vld = 0;
        swq.delete();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                nReset = 1'b0;
                #1;
                m_pc = 0; m_ir = 0; m_vld = 0;
                swq.delete();
                chk("rnd_rst_pc",    int'(ProgAddr),   0);
                chk("rnd_rst_valid", int'(InstrValid), 0);
                chk("rnd_rst_sw8",   int'(Sw8),        0);
                #1;
                nReset = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) SwRaw = 1'($urandom);
            r    = $urandom_range(0, 9);
            rtgt = 8'($urandom);
            if (m_vld == 0 || r < 6) rsel = PcInc;
            else if (r < 8)          rsel = PcWait;
            else                     rsel = PcJmp;
            step(rsel, rtgt);
            swq.push_back(SwRaw);
            if (swq.size() > 4) void'(swq.pop_front());
            if (rsel == PcInc) begin
                m_ir  = m_pc;
                m_vld = 1;
                m_pc  = (m_pc + 1) % 256;
            end else if (rsel == PcJmp) begin
                m_pc  = int'(rtgt);
                m_vld = 0;
            end
            chk("rnd_pc",    int'(ProgAddr),   m_pc);
            chk("rnd_instr", int'(Instr),      m_vld ? int'(rom[m_ir]) : 0);
            chk("rnd_expc",  int'(ExPc),       m_ir);
            chk("rnd_valid", int'(InstrValid), m_vld);
            chk("rnd_sw8",   int'(Sw8),        (swq.size() >= 2) ? int'(swq[swq.size()-2]) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
